inpkt_type_init_nb: RTL
=======================

Name: inpkt_type_init_nb

Overview:
- Receives the payload of a PKT_TYPE_INIT (0x05) packet as a byte stream from the pkt_comm input demux.
- Assembles the payload into one runtime-initialisation word of INIT_LEN bytes.
- Presents the word to the consumer core through an empty/rd_en handshake.
- Checks the packet length and flags malformed packets with a sticky error. This is the multi-byte successor of the 1-byte init holder.

Parameters:
- INIT_LEN, 4, payload length in bytes; legal range 1..16. The output word is 8*INIT_LEN bits wide.
- MSB_FIRST, 0, byte order. When 0, the first received byte goes to dout[7:0]. When 1, the first received byte goes to dout[8*INIT_LEN-1 -: 8].
- ERR_CLEARABLE, 0, error recovery mode. When 1, asserting err_clr leaves ERR and returns to RECV. When 0, only reset leaves ERR.

Ports:
- CLK  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- din  in  8  payload byte.
- wr_en  in  1  byte write strobe; the byte is accepted only when full=0.
- pkt_end  in  1  qualifies the current din as the last byte of the packet; meaningful only with an accepted write.
- full  out  1  block cannot accept a byte this cycle.
- dout  out  8*INIT_LEN  assembled init word.
- rd_en  in  1  consumer read; effective only when empty=0.
- empty  out  1  no complete word is available.
- err  out  1  sticky packet-length error.
- err_clr  in  1  clears the error; ignored unless ERR_CLEARABLE=1.

Behaviour:
- States: RECV, HOLD, ERR. A byte counter cnt has width clog2(INIT_LEN+1).
- Reset (synchronous, active-high) gives: state=RECV, cnt=0, dout=0, empty=1, err=0. Reset mid-packet discards any partial data.
- full=1 in HOLD and in ERR; full=0 in RECV. empty=0 only in HOLD. All outputs are registered.
- Accepted byte: wr_en & ~full.
- RECV, accepted byte:
  - The byte is written into the dout lane selected by cnt and MSB_FIRST. Other lanes are unchanged.
  - If cnt==INIT_LEN-1 and pkt_end=1: go to HOLD, cnt=0, empty=0 on the next cycle. Latency is 1 cycle from the last byte to empty deasserting.
  - If cnt==INIT_LEN-1 and pkt_end=0 (over-long packet): go to ERR, err=1.
  - If cnt<INIT_LEN-1 and pkt_end=1 (short packet): go to ERR, err=1, cnt=0.
  - Otherwise: cnt=cnt+1.
- HOLD:
  - dout stays stable.
  - rd_en=1 → empty=1, state=RECV on the next cycle.
  - A wr_en in the same cycle as rd_en is ignored, because full is still 1. The upstream must hold the byte.
  - dout keeps its old value after the read until it is overwritten lane by lane.
- ERR:
  - full=1, empty=1, err=1. No data is delivered.
  - If ERR_CLEARABLE=1 and err_clr=1: err=0, cnt=0, state=RECV on the next cycle. The dout lanes are not cleared.
  - err_clr in any other state has no effect.
- rd_en while empty=1 has no effect. wr_en while full=1 has no effect and raises no error.
- INIT_LEN=1: a single byte with pkt_end=1 goes to HOLD. A single byte without pkt_end goes to ERR.
- reset has priority over all other inputs in the same cycle.

Decomposition:
- The shared pkt_comm package/header holds:
  - PKT_TYPE_INIT = 8'h05
  - the INIT_LEN legal maximum (16)
  - the state encoding localparams (RECV, HOLD, ERR)
- No sub-module: a single flat module containing the FSM, the counter and the lane-write decoder.

Test Plan:
- INIT_LEN=4, MSB_FIRST=0: write 11,22,33,44 with pkt_end on 44 → one cycle later empty=0, dout=32'h44332211, full=1. Pulse rd_en → empty=1, full=0.
- INIT_LEN=4, MSB_FIRST=1: same bytes → dout=32'h11223344.
- Short packet: write AA, BB(pkt_end) → err=1, full=1, empty stays 1. With ERR_CLEARABLE=1, err_clr → err=0, after which a 4-byte packet is delivered correctly.
- Over-long packet: write 4 bytes without pkt_end → err=1 after the 4th byte. Further wr_en is ignored. With ERR_CLEARABLE=0, err_clr has no effect; only reset clears it.
- HOLD back-pressure: while empty=0, drive wr_en with 55 in the same cycle as rd_en → the byte is not accepted, and the next packet's first lane is taken from the following accepted write.
- Reset mid-packet after 2 bytes → cnt=0, err=0, empty=1; a full new packet then yields exactly its own 4 bytes. INIT_LEN=1 regression: 5A with pkt_end → dout=8'h5A.

Source files
------------

// File: rtl/inpkt_type_init_nb_pkg.sv
// Shared pkt_comm definitions for the multi-byte runtime-init packet receiver.
package inpkt_type_init_nb_pkg;

    localparam logic [7:0] PKT_TYPE_INIT = 8'h05;
    localparam int         INIT_LEN_MAX  = 16;

    // Receiver state encoding
    typedef enum logic [1:0] {
        RECV = 2'd0,
        HOLD = 2'd1,
        ERR  = 2'd2
    } init_state_t;

endpackage

// File: rtl/inpkt_type_init_nb_if.sv
// Byte-stream in / init-word out handshake bundle. The master side is the
// demux plus consumer core; the slave side is the init receiver.
interface inpkt_type_init_nb_if #(
    parameter int INIT_LEN = 4
);
    logic [7:0]            din;
    logic                  wr_en;
    logic                  pkt_end;
    logic                  full;
    logic [8*INIT_LEN-1:0] dout;
    logic                  rd_en;
    logic                  empty;
    logic                  err;
    logic                  err_clr;

    modport master (
        output din, wr_en, pkt_end, rd_en, err_clr,
        input  full, dout, empty, err
    );

    modport slave (
        input  din, wr_en, pkt_end, rd_en, err_clr,
        output full, dout, empty, err
    );
endinterface

// File: rtl/inpkt_type_init_nb.sv
// Assembles a PKT_TYPE_INIT payload into one INIT_LEN-byte word, hands it to
// the consumer through empty/rd_en, and flags wrong-length packets with a
// sticky error.
module inpkt_type_init_nb
    import inpkt_type_init_nb_pkg::*;
#(
    parameter int INIT_LEN      = 4,
    parameter int MSB_FIRST     = 0,
    parameter int ERR_CLEARABLE = 0
) (
    input  logic                 CLK,
    input  logic                 reset,
    inpkt_type_init_nb_if.slave  bus
);

    localparam int CW = $clog2(INIT_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(INIT_LEN - 1);

    if (INIT_LEN < 1 || INIT_LEN > INIT_LEN_MAX) begin : g_bad_len
        $error("INIT_LEN out of range 1..16");
    end

    init_state_t           state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [CW-1:0]         lane;
    logic                  lane_we;
    logic [8*INIT_LEN-1:0] dout_q;
    logic                  full_q, empty_q, err_q;

    // Lane addressed by the byte counter, mirrored when the first byte is the MSB
    always_comb begin
        lane = cnt;
        if (MSB_FIRST != 0) lane = LAST - cnt;
    end

    // Next-state, counter and lane-write decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lane_we   = 1'b0;
        case (state)
            RECV: begin
                // full is always 0 here, so wr_en alone means accepted
                if (bus.wr_en) begin
                    lane_we = 1'b1;
                    if (cnt == LAST) begin
                        state_nxt = bus.pkt_end ? HOLD : ERR;
                        cnt_nxt   = '0;
                    end else if (bus.pkt_end) begin
                        state_nxt = ERR;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                // writes in this state are blocked by full, including during the read
                if (bus.rd_en) state_nxt = RECV;
            end
            ERR: begin
                if (ERR_CLEARABLE != 0 && bus.err_clr) begin
                    state_nxt = RECV;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = RECV;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered status flags
    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= RECV;
            cnt     <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            full_q  <= (state_nxt != RECV);
            empty_q <= (state_nxt != HOLD);
            err_q   <= (state_nxt == ERR);
        end
    end

    // Word assembly: only the addressed lane changes; old lanes persist across packets
    always_ff @(posedge CLK) begin
        if (reset) begin
            dout_q <= '0;
        end else begin
            for (int i = 0; i < INIT_LEN; i++) begin
                if (lane_we && lane == CW'(i)) dout_q[8*i +: 8] <= bus.din;
            end
        end
    end

    assign bus.dout  = dout_q;
    assign bus.full  = full_q;
    assign bus.empty = empty_q;
    assign bus.err   = err_q;

endmodule
